// File: rtl/uart_mode_decoder.sv
// 8N1 UART receiver that decodes single-character commands into one-hot mode flags a..f.
// Define UART_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_mode_decoder #(
    parameter int unsigned CLK_HZ       = 25000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       cmd_valid,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitIdle
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StStop, StWaitIdle
    } state_e;
`endif

    state_e        state_q, state_d;
    logic          rx_meta_q, rxs_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [5:0]    flags_q;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q, cmd_valid_q;
    logic          par_ok;
    logic          cmd_hit;
    logic [5:0]    cmd_flags;
    logic [7:0]    lower;
    logic [2:0]    cmd_idx;

`ifdef UART_PARITY_EN
    logic par_err_q, par_err_d;
    assign par_ok = !par_err_q;
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            flags_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rx_valid_q  <= done_q;
            cmd_valid_q <= done_q && cmd_hit;
            if (done_q) rx_byte_q <= shift_q;
            if (done_q && cmd_hit) flags_q <= cmd_flags;
`ifdef UART_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d = par_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
`ifdef UART_PARITY_EN
                par_err_d = 1'b0;
`endif
                if (!rxs_q) begin
                    state_d = StStart;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    par_err_d = ^{shift_q, rxs_q};
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rxs_q && par_ok) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        err_d   = 1'b1;
                        state_d = rxs_q ? StIdle : StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (rxs_q) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Folding bit 5 maps 'A'..'F' onto 'a'..'f'; no other byte lands in that range.
    always_comb begin
        cmd_hit   = 1'b0;
        cmd_flags = '0;
        lower     = shift_q | 8'h20;
        cmd_idx   = lower[2:0] - 3'd1;
        if (shift_q == 8'h30) begin
            cmd_hit = 1'b1;
        end else if (lower >= 8'h61 && lower <= 8'h66) begin
            cmd_hit   = 1'b1;
            cmd_flags = 6'b000001 << cmd_idx;
        end
    end

    assign {f, e, d, c, b, a} = flags_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_uart_mode_decoder.sv
// Self-checking bench for uart_mode_decoder: directed command scenarios plus random frames
// checked every cycle against a behavioural frame/command model.
module tb_uart_mode_decoder;

    localparam int CPB  = 217;
`ifdef UART_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Stop-bit sample lands half a bit plus NBITS bits after the start edge, plus synchroniser.
    localparam int LAT_LO = 2 + CPB / 2 + NBITS * CPB;
    localparam int LAT_HI = LAT_LO + 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       a, b, c, d, e, f;
    logic [7:0] rx_byte;
    logic       rx_valid, cmd_valid, frame_err;
    logic [5:0] flags;

    typedef struct {
        logic [7:0] data;
        bit         err;
        int         start;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] model_flags = '0;
    int         pcyc = 0;
    int         total = 0;
    int         bad = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         n_cmd = 0;
    logic [7:0] cmds[13] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                             8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h30};

    uart_mode_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err)
    );

    assign flags = {f, e, d, c, b, a};

    always #20 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Returns {is_command, flags_after} from the command table.
    function automatic logic [6:0] model_cmd(input logic [7:0] ch, input logic [5:0] cur);
        if (ch == 8'h30) return {1'b1, 6'b0};
        if (ch >= 8'h41 && ch <= 8'h46) return {1'b1, 6'(6'd1 << (ch - 8'h41))};
        if (ch >= 8'h61 && ch <= 8'h66) return {1'b1, 6'(6'd1 << (ch - 8'h61))};
        return {1'b0, cur};
    endfunction

    always @(negedge clk) begin
        exp_t       ex;
        logic [6:0] r;
        int         dly;
        if (reset) begin
            model_flags = '0;
            check("reset_outputs", {flags, rx_byte, rx_valid, cmd_valid, frame_err}, '0);
        end else begin
            if (rx_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {rx_valid, frame_err}, 2'b00);
                end else begin
                    ex  = exp_q.pop_front();
                    dly = pcyc - ex.start;
                    check("frame_err_kind", frame_err, ex.err);
                    check("latency_in_window", (dly >= LAT_LO && dly <= LAT_HI), 1);
                    if (rx_valid) begin
                        n_valid++;
                        r = model_cmd(ex.data, model_flags);
                        check("rx_byte", rx_byte, ex.data);
                        check("cmd_valid", cmd_valid, r[6]);
                        model_flags = r[5:0];
                    end else begin
                        n_err++;
                        check("no_cmd_on_err", cmd_valid, 0);
                    end
                end
            end else begin
                check("cmd_valid_idle", cmd_valid, 0);
            end
            if (cmd_valid) n_cmd++;
            check("flags", flags, model_flags);
            check("flags_onehot", $countones(flags) <= 1, 1);
        end
    end

    task automatic bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        bits(n);
    endtask

    // Sends one frame; stop_bad drives a 0 stop bit, low_after keeps rx low for extra bits.
    task automatic send_frame(input logic [7:0] ch, input bit stop_bad, input bit par_flip,
                              input int low_after);
        exp_t ex;
        ex.data  = ch;
        ex.err   = stop_bad || par_flip;
        ex.start = pcyc;
        exp_q.push_back(ex);
        rx = 1'b0;
        bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = ch[i];
            bits(1);
        end
`ifdef UART_PARITY_EN
        rx = (^ch) ^ par_flip;
        bits(1);
`endif
        rx = !stop_bad;
        bits(1);
        if (stop_bad) begin
            rx = 1'b0;
            bits(low_after);
        end
        rx = 1'b1;
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, e0, c0;
        logic [7:0] ch;
        bit sb, pf;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_byte", rx_byte, 8'h00);
        reset = 1'b0;
        idle(1);

        // 'C'
        v0 = n_valid; c0 = n_cmd;
        send_frame(8'h43, 0, 0, 0);
        check("drain_C", exp_q.size(), 0);
        check("lit_C_byte", rx_byte, 8'h43);
        check("lit_C_flags", flags, 6'b000100);
        check("lit_C_pulses", {n_valid - v0, n_cmd - c0}, {32'd1, 32'd1});
        idle(1);

        // 'C' then 'f' back-to-back
        v0 = n_valid; c0 = n_cmd;
        send_frame(8'h43, 0, 0, 0);
        send_frame(8'h66, 0, 0, 0);
        check("drain_Cf", exp_q.size(), 0);
        check("lit_f_flags", flags, 6'b100000);
        check("lit_Cf_pulses", {n_valid - v0, n_cmd - c0}, {32'd2, 32'd2});
        idle(1);

        // 'e', then non-command 'Z', then '0'
        send_frame(8'h65, 0, 0, 0);
        c0 = n_cmd;
        send_frame(8'h5A, 0, 0, 0);
        check("lit_Z_byte", rx_byte, 8'h5A);
        check("lit_Z_flags", flags, 6'b010000);
        check("lit_Z_nocmd", n_cmd - c0, 0);
        send_frame(8'h30, 0, 0, 0);
        check("lit_0_flags", flags, 6'b000000);
        check("lit_0_cmd", n_cmd - c0, 1);
        idle(1);

        // 'A' with bad stop, line held low, then 'B'
        e0 = n_err;
        send_frame(8'h41, 1, 0, 3);
        check("lit_break_err", n_err - e0, 1);
        check("lit_break_a", a, 1'b0);
        idle(1);
        send_frame(8'h42, 0, 0, 0);
        check("lit_B_flags", flags, 6'b000010);
        idle(1);

        // 2 us glitch
        v0 = n_valid; e0 = n_err;
        rx = 1'b0;
        repeat (50) @(negedge clk);
        idle(2);
        check("lit_glitch_quiet", {n_valid - v0, n_err - e0}, 64'd0);
        send_frame(8'h64, 0, 0, 0);
        check("lit_glitch_then_d", flags, 6'b001000);
        idle(1);

        // Reset in the middle of a 'D' frame
        v0 = n_valid; e0 = n_err;
        rx = 1'b0;
        bits(1);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h44 >> i);
            bits(1);
        end
        #5 reset = 1'b1;
        #1 check("lit_async_d", d, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(1);
        check("lit_midreset_quiet", {n_valid - v0, n_err - e0}, 64'd0);
        send_frame(8'h44, 0, 0, 0);
        check("lit_D_after_reset", flags, 6'b001000);
        idle(1);

`ifdef UART_PARITY_EN
        send_frame(8'h41, 0, 0, 0);
        check("lit_par_A", flags, 6'b000001);
        e0 = n_err;
        send_frame(8'h42, 0, 1, 0);
        check("lit_par_err", n_err - e0, 1);
        check("lit_par_keep", flags, 6'b000001);
        idle(1);
`endif

        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(1, 0) == 1) ch = cmds[$urandom_range(12, 0)];
            else ch = 8'($urandom);
            sb = ($urandom_range(7, 0) == 0);
            pf = 1'b0;
`ifdef UART_PARITY_EN
            pf = ($urandom_range(7, 0) == 0);
`endif
            send_frame(ch, sb, pf, 0);
            check("drain_rand", exp_q.size(), 0);
            if (sb) idle(1 + $urandom_range(1, 0));
            else idle($urandom_range(2, 0));
            repeat ($urandom_range(40, 0)) @(negedge clk);
        end

        idle(1);
        check("final_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
